seq_mag_comparator: RTL and testbench

- Parametrised, digit-serial magnitude comparator for two W-bit operands, signed or unsigned, selected per operation.
- Scans MSB-first, DIGIT bits per clock, and terminates early at the first unequal digit.
- Uses a start/busy/done handshake and holds its less/equal/greater flags until the next accepted start.
- Sits beside the datapath as a shared compare resource where a full-width combinational comparator is too costly.

---
 rtl/seq_mag_comparator_pkg.sv | 24 ++
 rtl/seq_mag_comparator_if.sv | 41 ++++
 rtl/seq_mag_comparator_digit_cmp.sv | 24 ++
 rtl/seq_mag_comparator.sv | 160 ++++++++++++++++
 tb/tb_seq_mag_comparator.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mag_comparator_pkg.sv
// rtl/seq_mag_comparator_pkg.sv - shared types and constants for the digit-serial magnitude comparator
//
// Package seq_cmp_pkg
//   state_t      : controller states (IDLE, SCAN, DONE)
//   RES_*        : 2-bit encoding of a single digit comparison outcome
//   cnt_width()  : bit width needed to hold a digit count in 0..n
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_LT = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;

    // Width for a counter spanning 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// rtl/seq_mag_comparator_if.sv - request/result bundle for the digit-serial magnitude comparator
//
// Signals
//   start, signed_mode, a, b : request side, driven by the master
//   busy, done               : progress/handshake, driven by the comparator
//   less, equal, greater     : held result flags, driven by the comparator
//   digits_used              : digits examined for the last result
// Modports
//   master : requester view
//   slave  : comparator view
interface seq_mag_comparator_if #(
    parameter int W     = 8,
    parameter int DIGIT = 2
);
    import seq_cmp_pkg::*;

    localparam int N    = W / DIGIT;
    localparam int DU_W = cnt_width(N);

    logic            start;
    logic            signed_mode;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic            less;
    logic            equal;
    logic            greater;
    logic [DU_W-1:0] digits_used;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, less, equal, greater, digits_used
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, less, equal, greater, digits_used
    );

endinterface

// File: rtl/seq_mag_comparator_digit_cmp.sv
// rtl/seq_mag_comparator_digit_cmp.sv - combinational unsigned compare of one DIGIT-bit digit
//
// Ports
//   x, y : digits to compare (unsigned)
//   lt   : x < y
//   eq   : x == y
//   gt   : x > y
module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    always_comb begin
        lt = (x < y);
        eq = (x == y);
        gt = (x > y);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// rtl/seq_mag_comparator.sv - MSB-first digit-serial signed/unsigned magnitude comparator
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : seq_mag_comparator_if.slave
//          start/signed_mode/a/b in, busy/done/less/equal/greater/digits_used out
//
// A request captures both operands, then one DIGIT-bit digit per cycle is
// compared from the top down. The scan stops at the first unequal digit, so
// latency is the number of leading equal digits plus one.
module seq_mag_comparator
    import seq_cmp_pkg::*;
#(
    parameter int W     = 8,
    parameter int DIGIT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_mag_comparator_if.slave    bus
);

    localparam int N    = W / DIGIT;
    localparam int DU_W = cnt_width(N);

    // Flipping the sign bit maps two's complement onto offset binary, after
    // which an unsigned compare gives the signed ordering.
    localparam logic [W-1:0] MSB_MASK = W'(1) << (W - 1);

    state_t          state_q,   state_d;
    logic [W-1:0]    sa_q,      sa_d;
    logic [W-1:0]    sb_q,      sb_d;
    logic [DU_W-1:0] cnt_q,     cnt_d;
    logic [DU_W-1:0] du_q,      du_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic            less_q,    less_d;
    logic            equal_q,   equal_d;
    logic            greater_q, greater_d;

    logic            dig_lt;
    logic            dig_eq;
    logic            dig_gt;
    logic [1:0]      dig_res;

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .x  (sa_q[W-1 -: DIGIT]),
        .y  (sb_q[W-1 -: DIGIT]),
        .lt (dig_lt),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    always_comb begin
        if (dig_eq) begin
            dig_res = RES_EQ;
        end else if (dig_lt) begin
            dig_res = RES_LT;
        end else if (dig_gt) begin
            dig_res = RES_GT;
        end else begin
            dig_res = RES_EQ;
        end
    end

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        du_d      = du_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        less_d    = less_q;
        equal_d   = equal_q;
        greater_d = greater_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    sa_d      = bus.signed_mode ? (bus.a ^ MSB_MASK) : bus.a;
                    sb_d      = bus.signed_mode ? (bus.b ^ MSB_MASK) : bus.b;
                    cnt_d     = '0;
                    du_d      = '0;
                    less_d    = 1'b0;
                    equal_d   = 1'b0;
                    greater_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end else begin
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end

            SCAN: begin
                // start is deliberately not looked at here.
                if (dig_res != RES_EQ) begin
                    less_d    = (dig_res == RES_LT);
                    greater_d = (dig_res == RES_GT);
                    du_d      = cnt_q + DU_W'(1);
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == DU_W'(N - 1)) begin
                    equal_d   = 1'b1;
                    du_d      = DU_W'(N);
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    sa_d      = sa_q << DIGIT;
                    sb_d      = sb_q << DIGIT;
                    cnt_d     = cnt_q + DU_W'(1);
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            du_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            du_q      <= du_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.less        = less_q;
    assign bus.equal       = equal_q;
    assign bus.greater     = greater_q;
    assign bus.digits_used = du_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb/tb_seq_mag_comparator.sv - self-checking bench for seq_mag_comparator
module tb_seq_mag_comparator;

    localparam int W     = 8;
    localparam int DIGIT = 2;
    localparam int N     = W / DIGIT;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seq_mag_comparator_if #(.W(W), .DIGIT(DIGIT)) bus ();

    seq_mag_comparator #(.W(W), .DIGIT(DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ordering from plain integer arithmetic; digits examined is
    // the digit index of the highest differing bit plus one.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         output logic lt, output logic eq, output logic gt, output int k);
        int va;
        int vb;
        int p;
        logic [W-1:0] x;
        va = sm ? int'($signed(a)) : int'(a);
        vb = sm ? int'($signed(b)) : int'(b);
        lt = (va < vb);
        eq = (va == vb);
        gt = (va > vb);
        x  = a ^ b;
        if (x == '0) begin
            k = N;
        end else begin
            p = W - 1;
            while (p > 0 && !x[p]) p--;
            k = (W - 1 - p) / DIGIT + 1;
        end
    endtask

    // Called on a falling edge; returns on the falling edge where done is seen
    // (still inside the DONE cycle, so a new start can be chained directly).
    task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                              input string tag);
        logic e_lt, e_eq, e_gt;
        int   e_k;
        int   cycles;
        model(a, b, sm, e_lt, e_eq, e_gt, e_k);
        bus.start       = 1'b1;
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = sm;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.a           = $urandom;
        bus.b           = $urandom;
        bus.signed_mode = $urandom_range(0, 1);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/done after start: got %b/%b want 1/0", tag, bus.busy, bus.done);
        end
        checks++;
        if ({bus.less, bus.equal, bus.greater} !== 3'b000 || bus.digits_used !== 3'd0) begin
            errors++;
            $display("FAIL %s flags during scan: got lt/eq/gt=%b du=%0d want 000 du=0",
                     tag, {bus.less, bus.equal, bus.greater}, bus.digits_used);
        end
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < N + 4) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles, want done at %0d", tag, cycles, e_k);
        end else begin
            checks++;
            if (cycles != e_k) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", tag, cycles, e_k);
            end
            checks++;
            if ({bus.less, bus.equal, bus.greater} !== {e_lt, e_eq, e_gt} ||
                bus.digits_used !== 3'(e_k) || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s result a=%h b=%h s=%b: got lt/eq/gt=%b du=%0d busy=%b want %b du=%0d busy=0",
                         tag, a, b, sm, {bus.less, bus.equal, bus.greater}, bus.digits_used,
                         bus.busy, {e_lt, e_eq, e_gt}, e_k);
            end
        end
    endtask

    // One cycle after DONE with no start: idle, flags held.
    task automatic check_hold(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                              input string tag);
        logic e_lt, e_eq, e_gt;
        int   e_k;
        model(a, b, sm, e_lt, e_eq, e_gt, e_k);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            {bus.less, bus.equal, bus.greater} !== {e_lt, e_eq, e_gt} || bus.digits_used !== 3'(e_k)) begin
            errors++;
            $display("FAIL %s hold: got done=%b busy=%b lt/eq/gt=%b du=%0d want 0 0 %b du=%0d",
                     tag, bus.done, bus.busy, {bus.less, bus.equal, bus.greater},
                     bus.digits_used, {e_lt, e_eq, e_gt}, e_k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.less, bus.equal, bus.greater} !== 5'b0 || bus.digits_used !== 3'd0) begin
            errors++;
            $display("FAIL reset state: got busy/done/lt/eq/gt=%b du=%0d want 00000 du=0",
                     {bus.busy, bus.done, bus.less, bus.equal, bus.greater}, bus.digits_used);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_compare(8'h01, 8'h01, 1'b0, "eq_0101");   check_hold(8'h01, 8'h01, 1'b0, "eq_0101");
        do_compare(8'hC3, 8'h13, 1'b0, "gt_c313");   check_hold(8'hC3, 8'h13, 1'b0, "gt_c313");
        do_compare(8'hFF, 8'h01, 1'b1, "sgn_ff01");  check_hold(8'hFF, 8'h01, 1'b1, "sgn_ff01");
        do_compare(8'hFF, 8'h01, 1'b0, "uns_ff01");  check_hold(8'hFF, 8'h01, 1'b0, "uns_ff01");
    endtask

    task automatic test_mid_scan_ignore();
        int cycles;
        bus.start = 1'b1;
        bus.a = 8'h34;
        bus.b = 8'h37;
        bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < N + 4) begin
            if (cycles == 1) begin
                bus.start = 1'b1;
                bus.a = 8'h00;
                bus.b = 8'h00;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || cycles != 4 || {bus.less, bus.equal, bus.greater} !== 3'b100 ||
            bus.digits_used !== 3'd4) begin
            errors++;
            $display("FAIL mid_scan_start: got done=%b lat=%0d lt/eq/gt=%b du=%0d want 1 4 100 du=4",
                     bus.done, cycles, {bus.less, bus.equal, bus.greater}, bus.digits_used);
        end
        check_hold(8'h34, 8'h37, 1'b0, "mid_scan_start");
    endtask

    task automatic test_back_to_back();
        do_compare(8'h34, 8'h37, 1'b0, "b2b_first");
        do_compare(8'h80, 8'h7F, 1'b1, "b2b_second");
        do_compare(8'h12, 8'h12, 1'b1, "b2b_third");
        check_hold(8'h12, 8'h12, 1'b1, "b2b_third");
    endtask

    task automatic test_reset_mid_scan();
        bit saw_done;
        bus.start = 1'b1;
        bus.a = 8'h34;
        bus.b = 8'h37;
        bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.less, bus.equal, bus.greater} !== 5'b0 || bus.digits_used !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got busy/done/lt/eq/gt=%b du=%0d want 00000 du=0",
                     {bus.busy, bus.done, bus.less, bus.equal, bus.greater}, bus.digits_used);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_abort: got activity after reset want none");
        end
        do_compare(8'h34, 8'h37, 1'b0, "after_reset");
        check_hold(8'h34, 8'h37, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic sm;
        for (int i = 0; i < 150; i++) begin
            a  = $urandom;
            sm = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (8'h01 << $urandom_range(0, 7));
                default: b = $urandom;
            endcase
            do_compare(a, b, sm, "random");
            if ($urandom_range(0, 1) == 1) check_hold(a, b, sm, "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_mid_scan_ignore();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
